regfile_2r1w_init: RTL and testbench

- Parametrised successor to the processor's fixed 8-bit, 3-address register file (ports A1/A2 read, A3 write).
- Generalised data width and depth.
- Registered read ports with read-valid, write-to-read bypass, and a hardware clear sequencer that initialises every register after reset or on demand.
- Sits between decode (addresses, opcode fields) and the ALU inside the processor core.

---
 rtl/regfile_2r1w_init.sv | 127 ++++++++++++
 tb/tb_regfile_2r1w_init.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w_init.sv
// Parametrised 2-read/1-write register file with registered reads, bypass and clear sequencer.
// Optional ZERO_REG_EN: register 0 reads as zero and ignores writes.
module regfile_2r1w_init #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 3,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              re,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              rd_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wd;
    logic              w_rd_en;
    logic              w_wr_ok;
    logic              w_byp1;
    logic              w_byp2;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

`ifdef ZERO_REG_EN
    assign w_wr_ok = (A3 != '0);
`else
    assign w_wr_ok = 1'b1;
`endif

    assign w_byp1 = we && w_wr_ok && (A3 == A1);
    assign w_byp2 = we && w_wr_ok && (A3 == A2);

    always_comb begin
        w_rd1 = w_byp1 ? WD3 : r_mem[A1];
        w_rd2 = w_byp2 ? WD3 : r_mem[A2];
`ifdef ZERO_REG_EN
        // Entry 0 still gets cleared, but its contents are never visible.
        if (A1 == '0) w_rd1 = '0;
        if (A2 == '0) w_rd2 = '0;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_clr_idx;
        w_mem_we    = 1'b0;
        w_mem_addr  = A3;
        w_mem_wd    = WD3;
        w_rd_en     = 1'b0;
        unique case (r_state)
            S_INIT: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_idx;
                w_mem_wd   = INIT_VAL;
                if (&r_clr_idx) begin
                    w_state_nxt = S_READY;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_clr_idx + 1'b1;
                end
            end
            S_READY: begin
                if (clr) begin
                    w_state_nxt = S_INIT;
                    w_idx_nxt   = '0;
                end else begin
                    w_mem_we = we && w_wr_ok;
                    w_rd_en  = re;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_INIT;
            r_clr_idx  <= '0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_idx  <= w_idx_nxt;
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_rd1 <= w_rd1;
                r_rd2 <= w_rd2;
            end
        end
    end

    // Array has no reset; the sequencer owns its initial contents.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wd;
    end

    assign RD1      = r_rd1;
    assign RD2      = r_rd2;
    assign rd_valid = r_rd_valid;
    assign busy     = (r_state == S_INIT);

endmodule

// File: tb/tb_regfile_2r1w_init.sv
// Self-checking bench for regfile_2r1w_init: vector table with scoreboard queue
// plus hand-written clear/reset sequences.
module tb_regfile_2r1w_init;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam logic [DW-1:0] IV = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          we;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic          re;
    logic [AW-1:0] A1;
    logic [AW-1:0] A2;
    logic [DW-1:0] RD1;
    logic [DW-1:0] RD2;
    logic          rd_valid;
    logic          busy;

    regfile_2r1w_init #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .INIT_VAL(IV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .we      (we),
        .A3      (A3),
        .WD3     (WD3),
        .re      (re),
        .A1      (A1),
        .A2      (A2),
        .RD1     (RD1),
        .RD2     (RD2),
        .rd_valid(rd_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] a3;
        logic [DW-1:0] wd3;
        logic          re;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic          v;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
    } vec_t;

    typedef struct {
        int            idx;
        logic          v;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
    } exp_t;

    vec_t vecs [12];
    exp_t sb [$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 1'b0; we = 1'b0; re = 1'b0;
        A3 = '0; WD3 = '0; A1 = '0; A2 = '0;
    endtask

    // Counts edges until busy drops; expects exactly n cycles of busy.
    task automatic wait_clear(input string nm, input int n);
        for (int i = 1; i <= n; i++) begin
            tick();
            chk({nm, "_busy"}, busy, (i < n) ? 1 : 0);
            chk({nm, "_valid"}, rd_valid, 0);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [AW-1:0] a3,
                                input logic [DW-1:0] d, input logic r,
                                input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input logic v, input logic [DW-1:0] e1,
                                input logic [DW-1:0] e2);
        vec_t t;
        t.we = w; t.a3 = a3; t.wd3 = d; t.re = r; t.a1 = a1; t.a2 = a2;
        t.v = v; t.rd1 = e1; t.rd2 = e2;
        return t;
    endfunction

    initial begin
        exp_t e;
        logic [DW-1:0] z55;
`ifdef ZERO_REG_EN
        z55 = 8'h00;
`else
        z55 = 8'h55;
`endif
        vecs[0]  = mk(0, 0, 8'h00, 1, 0, 1, 1, IV, IV);
        vecs[1]  = mk(0, 0, 8'h00, 1, 2, 3, 1, IV, IV);
        vecs[2]  = mk(0, 0, 8'h00, 1, 4, 5, 1, IV, IV);
        vecs[3]  = mk(0, 0, 8'h00, 1, 6, 7, 1, IV, IV);
        vecs[4]  = mk(1, 5, 8'h3C, 0, 0, 0, 0, IV, IV);
        vecs[5]  = mk(0, 0, 8'h00, 1, 5, 2, 1, 8'h3C, IV);
        vecs[6]  = mk(0, 0, 8'h00, 0, 1, 1, 0, 8'h3C, IV);
        vecs[7]  = mk(1, 4, 8'h77, 1, 4, 4, 1, 8'h77, 8'h77);
        vecs[8]  = mk(0, 0, 8'h00, 1, 4, 5, 1, 8'h77, 8'h3C);
        vecs[9]  = mk(1, 2, 8'h5A, 1, 1, 2, 1, IV, 8'h5A);
        vecs[10] = mk(1, 0, 8'h55, 1, 0, 0, 1, z55, z55);
        vecs[11] = mk(0, 0, 8'h00, 1, 0, 3, 1, z55, IV);

        // Reset state, with accesses requested throughout reset and clear.
        idle();
        rst = 1'b0;
        we = 1'b1; A3 = 3; WD3 = 8'h11; re = 1'b1; A1 = 3; A2 = 3;
        #2;
        chk("rst_rd1", RD1, 0);
        chk("rst_rd2", RD2, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_busy", busy, 1);
        tick();
        tick();
        rst = 1'b1;
        wait_clear("init", 8);
        chk("init_rd1_held", RD1, 0);
        idle();

        // Table vectors through the scoreboard.
        for (int i = 0; i < 12; i++) begin
            we = vecs[i].we; A3 = vecs[i].a3; WD3 = vecs[i].wd3;
            re = vecs[i].re; A1 = vecs[i].a1; A2 = vecs[i].a2;
            e.idx = i; e.v = vecs[i].v; e.rd1 = vecs[i].rd1; e.rd2 = vecs[i].rd2;
            sb.push_back(e);
            tick();
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_valid", e.idx), rd_valid, e.v);
                chk($sformatf("v%0d_rd1", e.idx), RD1, e.rd1);
                chk($sformatf("v%0d_rd2", e.idx), RD2, e.rd2);
                chk($sformatf("v%0d_busy", e.idx), busy, 0);
            end
        end
        idle();

        // clr wins over a same-cycle write and read.
        clr = 1'b1; we = 1'b1; A3 = 1; WD3 = 8'hFF; re = 1'b1; A1 = 1; A2 = 1;
        tick();
        idle();
        chk("clr_busy", busy, 1);
        chk("clr_valid", rd_valid, 0);
        chk("clr_rd1_held", RD1, z55);
        wait_clear("clr", 8);
        re = 1'b1; A1 = 1; A2 = 5;
        tick();
        chk("clr_rd1", RD1, IV);
        chk("clr_rd2", RD2, IV);
        chk("clr_rvalid", rd_valid, 1);
        idle();

        // Reset pulse in the middle of a clear restarts it from index 0.
        we = 1'b1; A3 = 6; WD3 = 8'h99;
        tick();
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_rd1", RD1, 0);
        chk("mid_rst_rd2", RD2, 0);
        chk("mid_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        wait_clear("restart", 8);
        re = 1'b1; A1 = 6; A2 = 7;
        tick();
        chk("restart_rd1", RD1, IV);
        chk("restart_rd2", RD2, IV);
        chk("restart_valid", rd_valid, 1);
        idle();
        tick();
        chk("final_valid", rd_valid, 0);
        chk("final_rd1_held", RD1, IV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
